// File: rtl/m_arbiter_link_if.sv
// rtl/m_arbiter_link_if.sv - core handshake and serial arbiter lines of the master link engine
interface m_arbiter_link_if #(
  parameter int S_ID_WIDTH = 2
);
  logic                  req;
  logic [S_ID_WIDTH-1:0] slave_id;
  logic                  accept;
  logic                  release_pulse;
  logic                  yield_done;
  logic                  arb_out;
  logic                  arb_in;
  logic                  granted;
  logic                  suspended;
  logic                  resumed;
  logic                  timeout;
  logic                  proto_err;
  logic                  busy;

  // master: the core plus arbiter port around the engine
  modport master (
    output req, slave_id, accept, release_pulse, yield_done, arb_in,
    input  arb_out, granted, suspended, resumed, timeout, proto_err, busy
  );

  modport slave (
    input  req, slave_id, accept, release_pulse, yield_done, arb_in,
    output arb_out, granted, suspended, resumed, timeout, proto_err, busy
  );
endinterface

// File: rtl/m_arbiter_link.sv
// rtl/m_arbiter_link.sv - master-side serial link engine between core handshake and arbiter port
module m_arbiter_link #(
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int TIMEOUT    = 64
) (
  input logic             clk,
  input logic             rstN,
  m_arbiter_link_if.slave lnk
);

  localparam logic [3:0] IDLE         = 4'd0;
  localparam logic [3:0] SEND_REQ     = 4'd1;
  localparam logic [3:0] WAIT_GRANT   = 4'd2;
  localparam logic [3:0] SEND_ACK     = 4'd3;
  localparam logic [3:0] SEND_NAK     = 4'd4;
  localparam logic [3:0] WAIT_CONFIRM = 4'd5;
  localparam logic [3:0] OWN          = 4'd6;
  localparam logic [3:0] STOPPED      = 4'd7;
  localparam logic [3:0] SEND_YIELD   = 4'd8;

  localparam int TX_W  = 3 + S_ID_WIDTH;
  localparam int TXC_W = $clog2(TX_W + 1);
  localparam int WC_W  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] RX_GRANT   = 3'b011;
  localparam logic [2:0] RX_RESUME  = 3'b001;
  localparam logic [2:0] RX_CONFIRM = 3'b111;
  localparam logic [2:0] RX_SPLIT   = 3'b010;
  localparam logic [2:0] RX_PREEMPT = 3'b000;

  // TX frames are left-aligned in the shifter; shorter frames pad with zeros
  localparam logic [TX_W-1:0] F_ACK = {3'b101, {S_ID_WIDTH{1'b0}}};
  localparam logic [TX_W-1:0] F_NAK = {3'b110, {S_ID_WIDTH{1'b0}}};
  localparam logic [TX_W-1:0] F_ONE = {1'b1, {(TX_W-1){1'b0}}};

  logic [3:0]            state, state_d;
  logic [S_ID_WIDTH-1:0] sid_q;
  logic [WC_W-1:0]       wait_cnt;
  logic                  granted_q, suspended_q, busy_q;
  logic                  resumed_q, timeout_q, proto_err_q;
  logic                  granted_d, suspended_d;
  logic                  resumed_d, timeout_d, proto_err_d;
  logic                  sid_load, wait_clr;

  logic                  tx_busy, arb_out_q;
  logic [TXC_W-1:0]      tx_cnt;
  logic [TX_W-1:0]       tx_sr;
  logic                  tx_start;
  logic [TX_W-1:0]       tx_frame;
  logic [TXC_W-1:0]      tx_len;
  logic                  tx_last;

  logic                  rx_active, rx_valid;
  logic [1:0]            rx_cnt;
  logic [2:0]            rx_sr;
  logic                  rx_stop, wait_expired;

  // RX: start bit, three payload bits, frame valid for one cycle afterwards
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_active <= 1'b0;
      rx_valid  <= 1'b0;
      rx_cnt    <= 2'd0;
      rx_sr     <= 3'd0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_active) begin
        if (lnk.arb_in) begin
          rx_active <= 1'b1;
          rx_cnt    <= 2'd0;
        end
      end else begin
        rx_sr <= {rx_sr[1:0], lnk.arb_in};
        if (rx_cnt == 2'd2) begin
          rx_active <= 1'b0;
          rx_valid  <= 1'b1;
        end else begin
          rx_cnt <= rx_cnt + 2'd1;
        end
      end
    end
  end

  assign rx_stop      = (rx_sr == RX_SPLIT) || (rx_sr == RX_PREEMPT);
  assign tx_last      = tx_busy && (tx_cnt == '0);
  assign wait_expired = (wait_cnt == WC_W'(TIMEOUT - 1));

  // TX: the first bit is registered straight from the frame on start
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tx_busy   <= 1'b0;
      tx_cnt    <= '0;
      tx_sr     <= '0;
      arb_out_q <= 1'b0;
    end else if (tx_start) begin
      tx_busy   <= 1'b1;
      arb_out_q <= tx_frame[TX_W-1];
      tx_sr     <= tx_frame << 1;
      tx_cnt    <= tx_len - TXC_W'(1);
    end else if (tx_busy) begin
      if (tx_cnt == '0) begin
        tx_busy   <= 1'b0;
        arb_out_q <= 1'b0;
      end else begin
        arb_out_q <= tx_sr[TX_W-1];
        tx_sr     <= tx_sr << 1;
        tx_cnt    <= tx_cnt - TXC_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state;
    granted_d   = granted_q;
    suspended_d = suspended_q;
    resumed_d   = 1'b0;
    timeout_d   = 1'b0;
    proto_err_d = 1'b0;
    sid_load    = 1'b0;
    wait_clr    = 1'b0;
    tx_start    = 1'b0;
    tx_frame    = '0;
    tx_len      = '0;
    case (state)
      IDLE: begin
        proto_err_d = rx_valid;
        if (lnk.req) begin
          sid_load = 1'b1;
          state_d  = SEND_REQ;
        end
      end
      SEND_REQ: begin
        proto_err_d = rx_valid;
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_frame = {3'b111, sid_q};
          tx_len   = TXC_W'(TX_W);
        end else if (tx_last) begin
          state_d  = WAIT_GRANT;
          wait_clr = 1'b1;
        end
      end
      WAIT_GRANT: begin
        if (rx_valid) begin
          if ((rx_sr == RX_GRANT) || (rx_sr == RX_RESUME)) begin
            if (lnk.accept) begin
              state_d   = SEND_ACK;
              resumed_d = (rx_sr == RX_RESUME);
            end else begin
              state_d = SEND_NAK;
            end
          end else begin
            proto_err_d = 1'b1;
          end
        end else if (wait_expired) begin
          timeout_d   = 1'b1;
          suspended_d = 1'b0;
          state_d     = IDLE;
        end
      end
      SEND_ACK: begin
        proto_err_d = rx_valid;
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_frame = F_ACK;
          tx_len   = TXC_W'(3);
        end else if (tx_last) begin
          state_d  = WAIT_CONFIRM;
          wait_clr = 1'b1;
        end
      end
      SEND_NAK: begin
        proto_err_d = rx_valid;
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_frame = F_NAK;
          tx_len   = TXC_W'(3);
        end else if (tx_last) begin
          state_d     = IDLE;
          suspended_d = 1'b0;
        end
      end
      WAIT_CONFIRM: begin
        if (rx_valid) begin
          if (rx_sr == RX_CONFIRM) begin
            state_d     = OWN;
            granted_d   = 1'b1;
            suspended_d = 1'b0;
          end else begin
            proto_err_d = 1'b1;
          end
        end else if (wait_expired) begin
          timeout_d   = 1'b1;
          suspended_d = 1'b0;
          state_d     = IDLE;
        end
      end
      OWN: begin
        // a release beats a STOP decoded in the same cycle; the STOP is dropped
        if (lnk.release_pulse) begin
          tx_start    = 1'b1;
          tx_frame    = F_ONE;
          tx_len      = TXC_W'(1);
          granted_d   = 1'b0;
          state_d     = IDLE;
          proto_err_d = rx_valid && !rx_stop;
        end else if (rx_valid) begin
          if (rx_stop) begin
            granted_d   = 1'b0;
            suspended_d = 1'b1;
            state_d     = STOPPED;
          end else begin
            proto_err_d = 1'b1;
          end
        end
      end
      STOPPED: begin
        proto_err_d = rx_valid;
        if (lnk.yield_done) begin
          state_d = SEND_YIELD;
        end
      end
      SEND_YIELD: begin
        proto_err_d = rx_valid;
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_frame = F_ONE;
          tx_len   = TXC_W'(1);
        end else if (tx_last) begin
          state_d  = WAIT_GRANT;
          wait_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      sid_q       <= '0;
      wait_cnt    <= '0;
      granted_q   <= 1'b0;
      suspended_q <= 1'b0;
      busy_q      <= 1'b0;
      resumed_q   <= 1'b0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state       <= state_d;
      granted_q   <= granted_d;
      suspended_q <= suspended_d;
      busy_q      <= (state_d != IDLE);
      resumed_q   <= resumed_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
      if (sid_load) begin
        sid_q <= lnk.slave_id;
      end
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if ((state == WAIT_GRANT) || (state == WAIT_CONFIRM)) begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end
    end
  end

  assign lnk.arb_out   = arb_out_q;
  assign lnk.granted   = granted_q;
  assign lnk.suspended = suspended_q;
  assign lnk.busy      = busy_q;
  assign lnk.resumed   = resumed_q;
  assign lnk.timeout   = timeout_q;
  assign lnk.proto_err = proto_err_q;

endmodule

// File: doc/m_arbiter_link.md
Name: m_arbiter_link

Overview:
- Master-side serial link engine: directly upstream of the per-master arbiter port, driving that port's master-to-arbiter line and consuming its arbiter-to-master line.
- Turns the master core's parallel request/release handshake into serial REQ/ACK/NAK/END/YIELD frames.
- Decodes GRANT/RESUME/CONFIRM/STOP frames back into parallel status for the core.

Parameters:
- NO_SLAVES, 3, number of slaves on the bus.
- S_ID_WIDTH, $clog2(NO_SLAVES+1), width of the slave id field.
- TIMEOUT, 64, cycles allowed in WAIT_GRANT or WAIT_CONFIRM before abort.

Ports:
- clk  in  1  clock
- rstN  in  1  asynchronous active-low reset
- req  in  1  core requests the bus (level)
- slave_id  in  S_ID_WIDTH  target slave, sampled when req is accepted
- accept  in  1  core can take a grant now (1 → ACK, 0 → NAK)
- release  in  1  core finished the transaction (1-cycle pulse)
- yield_done  in  1  core has parked after a STOP (1-cycle pulse)
- arb_out  out  1  serial line to the arbiter port, idle 0
- arb_in  in  1  serial line from the arbiter port, idle 0
- granted  out  1  core owns the bus
- suspended  out  1  stopped by split or pre-emption, awaiting re-grant
- resumed  out  1  1-cycle pulse: grant was a RESUME (split continuation)
- timeout  out  1  1-cycle pulse on wait abort
- proto_err  out  1  1-cycle pulse on an unexpected received frame
- busy  out  1  state != IDLE

Behaviour:
- Reset: every output 0 and arb_out 0; FSM in IDLE; counters and shift registers cleared. Reset mid-frame aborts immediately with no partial frame.
- Serial order: MSB first, one bit per clk. arb_out is registered, so bit 0 of a frame appears the cycle after the FSM decides to send.

TX frames (master → arbiter):
- REQ = 1,1,1, then slave_id, MSB first (3+S_ID_WIDTH bits).
- ACK = 1,0,1.
- NAK = 1,1,0.
- END = single 1.
- YIELD = single 1.
- arb_out returns to 0 after each frame; a TX busy flag blocks new frames while one is in flight.

RX decoder:
- Idle 0. A 1 is the start bit, followed by a 3-bit payload. The frame is valid the cycle after the last payload bit.
- Payloads: GRANT = 011, RESUME = 001, CONFIRM = 111, STOP_SPLIT = 010, STOP_PREEMPT = 000.
- After a frame the decoder hunts for the next start bit.
- RX runs independently of TX, including during transmission.

FSM states: IDLE, SEND_REQ, WAIT_GRANT, SEND_ACK, SEND_NAK, WAIT_CONFIRM, OWN, STOPPED, SEND_YIELD.
- IDLE: req=1 → latch slave_id, go to SEND_REQ. req is ignored in every other state.
- SEND_REQ: after the last REQ bit → WAIT_GRANT; clear the wait counter.
- WAIT_GRANT, on GRANT or RESUME:
  - accept=1 → SEND_ACK; pulse resumed if the frame was RESUME.
  - accept=0 → SEND_NAK.
  - SEND_NAK then → IDLE; suspended is cleared.
- SEND_ACK: after the frame → WAIT_CONFIRM; clear the wait counter.
- WAIT_CONFIRM: CONFIRM → OWN; granted=1 and suspended=0 in the same cycle.
- Wait counter: increments each cycle in WAIT_GRANT and WAIT_CONFIRM. Reaching TIMEOUT-1 → pulse timeout, go to IDLE, clear suspended. Counter width is $clog2(TIMEOUT+1).
- OWN, release:
  - release → send END, granted=0 the next cycle, → IDLE.
  - release and a STOP frame valid in the same cycle: release wins; the STOP is dropped and proto_err is not raised.
- OWN, STOP_SPLIT or STOP_PREEMPT: granted=0 and suspended=1 the next cycle → STOPPED.
- STOPPED: yield_done → SEND_YIELD; after the pulse → WAIT_GRANT (suspended stays 1); clear the wait counter.
- Any other valid frame in any other state: pulse proto_err, state unchanged.
- granted, suspended and busy are registered.
- Worst-case hold in OWN is unbounded; no timeout applies there.

Test Plan:
- Basic grant (NO_SLAVES=3): req=1, slave_id=2'b10.
  - arb_out = 0,1,1,1,1,0,0 starting the cycle after req.
  - Return GRANT (1,0,1,1) with accept=1 → arb_out 1,0,1.
  - Return CONFIRM (1,1,1,1) → granted=1.
  - release pulse → arb_out single 1, granted=0, busy=0.
- NAK path: GRANT with accept=0 → arb_out 1,1,0, FSM back in IDLE, granted never asserted.
- Split: in OWN, send STOP_SPLIT (1,0,1,0) → granted=0, suspended=1.
  - yield_done → arb_out single 1.
  - RESUME (1,0,0,1) → resumed pulse, ACK sent.
  - CONFIRM → granted=1, suspended=0.
- Timeout (TIMEOUT=8): after REQ, hold arb_in=0 → timeout pulses exactly 8 cycles after entering WAIT_GRANT, then busy=0.
- Collision and error:
  - release in the same cycle a STOP_PREEMPT decodes → END sent, IDLE, no proto_err.
  - CONFIRM received in IDLE → proto_err pulse only.
- Reset mid-REQ: assert rstN=0 on the 2nd REQ bit → arb_out=0 immediately and all outputs 0. Release reset → next req restarts a full REQ frame.
